// File: rtl/sdram_init_ref.sv
// SDRAM power-up sequencer and periodic AUTO REFRESH scheduler.
// After init it borrows the command bus through ref_req/ref_ack.
module sdram_init_ref #(
    parameter int          INIT_WAIT    = 5000,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          REF_INTERVAL = 390,
    parameter logic [12:0] MODE         = 13'h0022
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cke,
    output logic [2:0]  cmd,
    output logic [12:0] addr,
    output logic [1:0]  ba,
    output logic        own,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_miss
);

    localparam int M1   = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int M2   = (M1 > T_MRD) ? M1 : T_MRD;
    localparam int MAXT = (INIT_WAIT > M2) ? INIT_WAIT : M2;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int IW   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    localparam logic [3:0] S_WAIT_PWR = 4'd0;
    localparam logic [3:0] S_PRE      = 4'd1;
    localparam logic [3:0] S_PRE_W    = 4'd2;
    localparam logic [3:0] S_REF1     = 4'd3;
    localparam logic [3:0] S_REF1_W   = 4'd4;
    localparam logic [3:0] S_REF2     = 4'd5;
    localparam logic [3:0] S_REF2_W   = 4'd6;
    localparam logic [3:0] S_MRS      = 4'd7;
    localparam logic [3:0] S_MRS_W    = 4'd8;
    localparam logic [3:0] S_IDLE     = 4'd9;
    localparam logic [3:0] S_REQ      = 4'd10;
    localparam logic [3:0] S_AREF     = 4'd11;
    localparam logic [3:0] S_AREF_W   = 4'd12;

    logic [3:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_icnt;
    logic          r_cke;
    logic [2:0]    r_cmd;
    logic [12:0]   r_addr;
    logic          r_own;
    logic          r_done;
    logic          r_req;
    logic          r_pending;
    logic          r_miss;

    logic          w_wrap;
    logic          w_grant;
    logic          w_zero;

    assign w_wrap  = r_done && (r_icnt == IW'(REF_INTERVAL - 1));
    assign w_grant = (r_state == S_REQ) && ref_ack;
    assign w_zero  = (r_cnt == '0);

    // Wait counter is loaded with T-1 at issue and runs down to zero,
    // so the next command lands exactly T cycles after this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_PWR;
            r_cnt   <= CW'(INIT_WAIT);
            r_cke   <= 1'b0;
            r_cmd   <= C_NOP;
            r_addr  <= '0;
            r_own   <= 1'b1;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_cke  <= 1'b1;
            r_cmd  <= C_NOP;
            r_addr <= '0;
            case (r_state)
                S_WAIT_PWR, S_PRE_W, S_REF1_W, S_REF2_W, S_MRS_W, S_AREF_W: begin
                    if (!w_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        case (r_state)
                            S_WAIT_PWR: begin
                                r_state <= S_PRE;
                                r_cmd   <= C_PRE;
                                r_addr  <= 13'h0400;
                                r_cnt   <= CW'(T_RP - 1);
                            end
                            S_PRE_W: begin
                                r_state <= S_REF1;
                                r_cmd   <= C_REF;
                                r_cnt   <= CW'(T_RFC - 1);
                            end
                            S_REF1_W: begin
                                r_state <= S_REF2;
                                r_cmd   <= C_REF;
                                r_cnt   <= CW'(T_RFC - 1);
                            end
                            S_REF2_W: begin
                                r_state <= S_MRS;
                                r_cmd   <= C_MRS;
                                r_addr  <= MODE;
                                r_cnt   <= CW'(T_MRD - 1);
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                                r_own   <= 1'b0;
                            end
                        endcase
                    end
                end
                S_PRE: begin
                    r_state <= S_PRE_W;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_REF1: begin
                    r_state <= S_REF1_W;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_REF2: begin
                    r_state <= S_REF2_W;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_MRS: begin
                    r_state <= S_MRS_W;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_AREF: begin
                    r_state <= S_AREF_W;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_IDLE: begin
                    if (r_pending) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ref_ack) begin
                        r_state <= S_AREF;
                        r_cmd   <= C_REF;
                        r_own   <= 1'b1;
                        r_req   <= 1'b0;
                        r_cnt   <= CW'(T_RFC - 1);
                    end
                end
                default: r_state <= S_WAIT_PWR;
            endcase
        end
    end

    // Deadline counter; a wrap with a refresh still outstanding is a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_icnt    <= '0;
            r_pending <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            if (r_done) begin
                r_icnt <= w_wrap ? '0 : r_icnt + IW'(1);
            end
            if (w_wrap) begin
                r_pending <= 1'b1;
                if (r_pending && !w_grant) begin
                    r_miss <= 1'b1;
                end
            end else if (w_grant) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign cke       = r_cke;
    assign cmd       = r_cmd;
    assign addr      = r_addr;
    assign ba        = 2'b00;
    assign own       = r_own;
    assign init_done = r_done;
    assign ref_req   = r_req;
    assign ref_miss  = r_miss;

endmodule

// File: tb/tb_sdram_init_ref.sv
// Bench for sdram_init_ref: per-cycle scoreboard against a table of
// spec-derived command schedules, plus reset and abort sequences.
module tb_sdram_init_ref;

    localparam int IW   = 10;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam int TMRD = 2;
    localparam int RI   = 20;

    localparam int C_PRE  = IW;
    localparam int C_REF1 = IW + TRP;
    localparam int C_REF2 = C_REF1 + TRFC;
    localparam int C_MRS  = C_REF2 + TRFC;
    localparam int C_DONE = C_MRS + TMRD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ref_ack = 1'b0;
    logic        cke;
    logic [2:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        own;
    logic        init_done;
    logic        ref_req;
    logic        ref_miss;

    sdram_init_ref #(
        .INIT_WAIT   (IW),
        .T_RP        (TRP),
        .T_RFC       (TRFC),
        .T_MRD       (TMRD),
        .REF_INTERVAL(RI),
        .MODE        (13'h0022)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cke      (cke),
        .cmd      (cmd),
        .addr     (addr),
        .ba       (ba),
        .own      (own),
        .init_done(init_done),
        .ref_req  (ref_req),
        .ref_ack  (ref_ack),
        .ref_miss (ref_miss)
    );

    always #5 clk = ~clk;

    typedef logic signed [31:0] i32_t;

    typedef struct packed {
        logic        cke;
        logic [2:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic        own;
        logic        done;
        logic        req;
        logic        miss;
    } obs_t;

    // Inputs: ack_from (ack high from this cycle on), last cycle.
    // Expected: refresh cycles, ref_req windows, first ref_miss cycle.
    typedef struct {
        string      nm;
        int         ack_from;
        int         last;
        int         miss_from;
        i32_t [3:0] ref_at;
        i32_t [3:0] req_lo;
        i32_t [3:0] req_hi;
    } vec_t;

    vec_t tbl [4];
    obs_t sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic obs_t exp_rst();
        obs_t e;
        e      = '0;
        e.cmd  = 3'b111;
        e.own  = 1'b1;
        return e;
    endfunction

    function automatic obs_t exp_at(int r, int c);
        obs_t e;
        e      = '0;
        e.cke  = 1'b1;
        e.cmd  = 3'b111;
        e.own  = (c < C_DONE);
        e.done = (c >= C_DONE);
        e.miss = (tbl[r].miss_from >= 0) && (c >= tbl[r].miss_from);
        if (c == C_PRE) begin
            e.cmd  = 3'b010;
            e.addr = 13'h0400;
        end
        if (c == C_REF1 || c == C_REF2) e.cmd = 3'b001;
        if (c == C_MRS) begin
            e.cmd  = 3'b000;
            e.addr = 13'h0022;
        end
        for (int i = 0; i < 4; i++) begin
            if (tbl[r].ref_at[i] >= 0) begin
                if (c == int'(tbl[r].ref_at[i])) e.cmd = 3'b001;
                if (c >= int'(tbl[r].ref_at[i]) && c < int'(tbl[r].ref_at[i]) + TRFC)
                    e.own = 1'b1;
            end
            if (tbl[r].req_lo[i] >= 0 && c >= int'(tbl[r].req_lo[i])
                && c <= int'(tbl[r].req_hi[i]))
                e.req = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input obs_t e, input logic rs, input logic ak,
                        input string nm, input int c);
        obs_t a;
        obs_t x;
        rst     = rs;
        ref_ack = ak;
        sb.push_back(e);
        @(posedge clk);
        #1;
        a = {cke, cmd, addr, ba, own, init_done, ref_req, ref_miss};
        x = sb.pop_front();
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got cke=%b cmd=%b addr=%h ba=%b own=%b done=%b req=%b miss=%b, expected cke=%b cmd=%b addr=%h ba=%b own=%b done=%b req=%b miss=%b",
                     nm, c, a.cke, a.cmd, a.addr, a.ba, a.own, a.done, a.req, a.miss,
                     x.cke, x.cmd, x.addr, x.ba, x.own, x.done, x.req, x.miss);
        end
    endtask

    initial begin
        tbl[0].nm        = "granted";
        tbl[0].ack_from  = -100;
        tbl[0].last      = 115;
        tbl[0].miss_from = -1;
        tbl[0].ref_at    = {i32_t'(50), i32_t'(70), i32_t'(90), i32_t'(110)};
        tbl[0].req_lo    = {i32_t'(49), i32_t'(69), i32_t'(89), i32_t'(109)};
        tbl[0].req_hi    = {i32_t'(49), i32_t'(69), i32_t'(89), i32_t'(109)};

        tbl[1].nm        = "delayed";
        tbl[1].ack_from  = 63;
        tbl[1].last      = 115;
        tbl[1].miss_from = -1;
        tbl[1].ref_at    = {i32_t'(64), i32_t'(73), i32_t'(90), i32_t'(110)};
        tbl[1].req_lo    = {i32_t'(49), i32_t'(72), i32_t'(89), i32_t'(109)};
        tbl[1].req_hi    = {i32_t'(63), i32_t'(72), i32_t'(89), i32_t'(109)};

        tbl[2].nm        = "missed";
        tbl[2].ack_from  = 94;
        tbl[2].last      = 115;
        tbl[2].miss_from = 68;
        tbl[2].ref_at    = {i32_t'(95), i32_t'(110), i32_t'(-1), i32_t'(-1)};
        tbl[2].req_lo    = {i32_t'(49), i32_t'(109), i32_t'(-1), i32_t'(-1)};
        tbl[2].req_hi    = {i32_t'(94), i32_t'(109), i32_t'(-1), i32_t'(-1)};

        tbl[3].nm        = "restart";
        tbl[3].ack_from  = 100000;
        tbl[3].last      = 30;
        tbl[3].miss_from = -1;
        tbl[3].ref_at    = {4{i32_t'(-1)}};
        tbl[3].req_lo    = {4{i32_t'(-1)}};
        tbl[3].req_hi    = {4{i32_t'(-1)}};

        for (int i = 0; i < 5; i++)
            step(exp_rst(), 1'b1, 1'b1, "reset_hold", i);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2; i++)
                step(exp_rst(), 1'b1, 1'b0, "row_reset", i);
            for (int c = 0; c <= tbl[r].last; c++)
                step(exp_at(r, c), 1'b0, logic'(c > tbl[r].ack_from), tbl[r].nm, c);
        end

        for (int i = 0; i < 2; i++)
            step(exp_rst(), 1'b1, 1'b0, "pre_abort_reset", i);
        for (int c = 0; c <= 15; c++)
            step(exp_at(3, c), 1'b0, 1'b0, "pre_abort", c);
        for (int c = 16; c <= 18; c++)
            step(exp_rst(), 1'b1, 1'b0, "abort_reset", c);
        for (int c = 0; c <= tbl[3].last; c++)
            step(exp_at(3, c), 1'b0, 1'b0, tbl[3].nm, c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_init_ref.md
# sdram_init_ref

Command sequencer for the SDRAM port of the memspeed experiment. After `rst` falls it runs the JEDEC power-up sequence (wait, PRECHARGE ALL, two AUTO REFRESH, LOAD MODE REGISTER). It then schedules periodic AUTO REFRESH, borrowing the command bus from the access controller through a request/acknowledge handshake. It runs entirely on the DCM-deskewed `clk`; its `rst` is the counter-stretched reset from the clock/reset generator.

## Interface
- INIT_WAIT, 5000 — power-up wait in clk cycles (100 us at 50 MHz)
- T_RP, 2 — PRECHARGE to next command, cycles
- T_RFC, 7 — AUTO REFRESH to next command, cycles
- T_MRD, 2 — LOAD MODE to next command, cycles
- REF_INTERVAL, 390 — cycles between refresh deadlines (7.8 us at 50 MHz)
- MODE, 13'h0022 — mode register value: CAS latency 2, sequential, burst length 4
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cke  out  1  SDRAM clock enable
- cmd  out  3  {ras_n, cas_n, we_n}; NOP = 3'b111
- addr  out  13  SDRAM address; A10 = 1 for PRECHARGE ALL, MODE for LOAD MODE, else 0
- ba  out  2  bank address; always 2'b00
- own  out  1  block drives the command bus; mux select for the top level
- init_done  out  1  initialization complete (sticky until rst)
- ref_req  out  1  refresh due; requests the bus
- ref_ack  in  1  access controller idle; grants the bus
- ref_miss  out  1  sticky: a deadline passed while a refresh was still pending

## Operation
- Commands: NOP 111, PRECHARGE 010, AUTO REFRESH 001, LOAD MODE 000.
- Every command occupies exactly one cycle; all other cycles drive NOP.
- Reset values: cke=0, cmd=111, addr=0, ba=0, own=1, init_done=0, ref_req=0, ref_miss=0, state=WAIT_PWR.
- cke=1 from the first cycle after `rst` deasserts, for as long as `rst` stays low.
- States and transitions:
  - WAIT_PWR: counts INIT_WAIT cycles, then → PRE.
  - PRE: issues PRECHARGE with A10=1 → PRE_W.
  - PRE_W: waits T_RP−1 cycles → REF1.
  - REF1: issues AUTO REFRESH → REF1_W.
  - REF1_W: waits T_RFC−1 cycles → REF2.
  - REF2: issues AUTO REFRESH → REF2_W.
  - REF2_W: waits T_RFC−1 cycles → MRS.
  - MRS: issues LOAD MODE with addr=MODE → MRS_W.
  - MRS_W: waits T_MRD−1 cycles → IDLE; init_done=1 and own=0 on IDLE entry.
  - IDLE: when a refresh is pending, asserts ref_req → REQ.
  - REQ: holds ref_req; when ref_ack=1 sampled, → AREF with own=1.
  - AREF: issues AUTO REFRESH; ref_req=0; clears the pending flag → AREF_W.
  - AREF_W: waits T_RFC−1 cycles → IDLE; own=0 on IDLE entry.
- The wait counter is loaded at command issue. The next command falls exactly T cycles after the previous one.
- Interval counter:
  - Width ceil(log2(REF_INTERVAL)).
  - Starts at 0 on IDLE entry after init.
  - Free-runs and wraps at REF_INTERVAL−1.
  - On each wrap it sets `pending`.
  - If pending is already set at a wrap, ref_miss is set. pending stays a single flag; no catch-up burst.
- `rst` asserted in any state forces all reset values on the next edge, including mid-sequence and during AREF_W. Aborting a refresh in progress is legal because cke drops.

## Timing
- Cycle numbering: cycle 0 is the first rising edge with rst=0.
- Command schedule:
  - PRECHARGE at cycle INIT_WAIT.
  - REF1 at INIT_WAIT+T_RP.
  - REF2 at INIT_WAIT+T_RP+T_RFC.
  - MRS at INIT_WAIT+T_RP+2·T_RFC.
  - init_done rises at INIT_WAIT+T_RP+2·T_RFC+T_MRD.
- ref_req rises one cycle after the wrap that sets pending.
- AUTO REFRESH issues the cycle after ref_ack is sampled high. ref_ack is only sampled in REQ.
- ref_ack while ref_req=0 is ignored.
- own rises in the same cycle as AUTO REFRESH and falls T_RFC cycles later.
- The access controller must not drive the command bus from the cycle it asserts ref_ack until it sees own fall.
- The interval counter keeps counting during REQ/AREF/AREF_W. A deadline during AREF_W sets pending again: no miss, because pending was cleared in AREF.

## Test plan
- **Init schedule.** INIT_WAIT=10, T_RP=2, T_RFC=7, T_MRD=2; release rst → cmd 010/A10=1 at cycle 10, 001 at 12 and 19, 000 with addr=0x022 at 26, init_done=1 at 28, cmd=111 everywhere else.
- **Reset values.** Hold rst high 5 cycles → cke=0, cmd=111, own=1, init_done=0, ref_req=0, ref_miss=0 throughout.
- **Granted refresh.** REF_INTERVAL=20, ref_ack tied high → AUTO REFRESH every 20 cycles, own high for 7 cycles each time, ref_miss stays 0.
- **Delayed grant.** Hold ref_ack low 15 cycles after ref_req → ref_req held steady, cmd=111, own=0; refresh issues the cycle after ref_ack rises.
- **Missed deadline.** Hold ref_ack low for 45 cycles with REF_INTERVAL=20 → ref_miss=1 at the second wrap; one refresh issued on grant; ref_miss remains 1 until rst.
- **Reset mid-sequence.** Assert rst during REF1_W, release → full sequence restarts from WAIT_PWR with the identical cycle schedule.
